// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Operand width used when the instantiating level does not override it.
  localparam int WIDTH_DEFAULT = 8;

  // Controller states; the encoding is fixed so debug probes can decode it.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full subtractor: x - y - bin, giving a difference bit and a borrow-out.
// Outputs come first in the port list, matching the fulladder cell.
module fullsubtractor (
  output logic diff,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per clock, LSB first.
//
// Handshake: start is accepted on any rising edge where the controller is in
// IDLE or DONE; a, b and bin are captured on that same edge. While busy is high,
// start is ignored and the captured operands are frozen. done pulses for exactly
// one cycle when diff/borrow have been refreshed; they then hold until the next
// result or reset. Asserting start while done is high chains the next operation
// with no idle cycle.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output state_t           state_dbg
);

  // Counter carries one spare bit above what indexing needs; the bit index uses
  // only the low bits, and the end-of-run compare uses the full counter.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = CW - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             br;
  logic [WIDTH-1:0] diff_acc;

  logic [IW-1:0]    idx;
  logic             abit;
  logic             bbit;
  logic             dbit;
  logic             bnext;
  logic             last;
  logic [WIDTH-1:0] diff_next;

  assign state_dbg = state;

  // Select the current bit pair and merge the new difference bit into the accumulator.
  always_comb begin
    idx       = cnt[IW-1:0];
    abit      = a_r[idx];
    bbit      = b_r[idx];
    last      = (cnt == LAST);
    diff_next = diff_acc;
    diff_next[idx] = dbit;
  end

  fullsubtractor u_fs (
    .diff (dbit),
    .bout (bnext),
    .x    (abit),
    .y    (bbit),
    .bin  (br)
  );

  // Controller: capture operands on start, step one bit per RUN edge, publish on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      br       <= 1'b0;
      diff_acc <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            br       <= bin;
            cnt      <= '0;
            diff_acc <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          diff_acc <= diff_next;
          br       <= bnext;
          if (last) begin
            cnt    <= '0;
            diff   <= diff_next;
            borrow <= bnext;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit and a 3-bit instance, each shadowed by a
// cycle-level arithmetic model that is compared on every falling edge, plus
// directed operations with hand-computed results.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic       start8, bin8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;
  state_t     st8;

  logic       start3, bin3, busy3, done3, borrow3;
  logic [2:0] a3, b3, diff3;
  state_t     st3;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .state_dbg(st8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3), .state_dbg(st3)
  );

  // ---------------- scoreboard counters ----------------
  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural models ----------------
  // Each model treats an operation as a timer of WIDTH cycles after the accept
  // edge; the result is plain wide arithmetic computed at accept time.
  logic       m8_busy, m8_done, m8_borrow, m8_pbor;
  logic [7:0] m8_diff, m8_pdiff;
  int         m8_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_busy <= 0; m8_done <= 0; m8_diff <= 0; m8_borrow <= 0;
      m8_pdiff <= 0; m8_pbor <= 0; m8_rem <= 0;
    end else begin
      m8_done <= 1'b0;
      if (m8_rem > 0) begin
        m8_rem <= m8_rem - 1;
        if (m8_rem == 1) begin
          m8_busy   <= 1'b0;
          m8_done   <= 1'b1;
          m8_diff   <= m8_pdiff;
          m8_borrow <= m8_pbor;
        end
      end else if (start8) begin
        {m8_pbor, m8_pdiff} <= {1'b0, a8} - {1'b0, b8} - 9'(bin8);
        m8_rem  <= 8;
        m8_busy <= 1'b1;
      end
    end
  end

  logic       m3_busy, m3_done, m3_borrow, m3_pbor;
  logic [2:0] m3_diff, m3_pdiff;
  int         m3_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m3_busy <= 0; m3_done <= 0; m3_diff <= 0; m3_borrow <= 0;
      m3_pdiff <= 0; m3_pbor <= 0; m3_rem <= 0;
    end else begin
      m3_done <= 1'b0;
      if (m3_rem > 0) begin
        m3_rem <= m3_rem - 1;
        if (m3_rem == 1) begin
          m3_busy   <= 1'b0;
          m3_done   <= 1'b1;
          m3_diff   <= m3_pdiff;
          m3_borrow <= m3_pbor;
        end
      end else if (start3) begin
        {m3_pbor, m3_pdiff} <= {1'b0, a3} - {1'b0, b3} - 4'(bin3);
        m3_rem  <= 3;
        m3_busy <= 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("busy8",   32'(busy8),   32'(m8_busy));
      check("done8",   32'(done8),   32'(m8_done));
      check("diff8",   32'(diff8),   32'(m8_diff));
      check("borrow8", 32'(borrow8), 32'(m8_borrow));
      check("state8",  32'(st8),     m8_busy ? 32'(RUN) : (m8_done ? 32'(DONE) : 32'(IDLE)));
      check("busy3",   32'(busy3),   32'(m3_busy));
      check("done3",   32'(done3),   32'(m3_done));
      check("diff3",   32'(diff3),   32'(m3_diff));
      check("borrow3", 32'(borrow3), 32'(m3_borrow));
      check("state3",  32'(st3),     m3_busy ? 32'(RUN) : (m3_done ? 32'(DONE) : 32'(IDLE)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input logic [7:0] ed, input logic eb, input string name);
    int n;
    @(negedge clk);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd9);
    check({name, "_diff"},    32'(diff8), 32'(ed));
    check({name, "_borrow"},  32'(borrow8), 32'(eb));
  endtask

  task automatic op3(input logic [2:0] ta, input logic [2:0] tb, input logic tbin);
    int n;
    logic [3:0] r;
    @(negedge clk);
    a3 = ta; b3 = tb; bin3 = tbin; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 1;
    while (!done3 && n < 12) begin
      @(negedge clk);
      n++;
    end
    r = {1'b0, ta} - {1'b0, tb} - 4'(tbin);
    check("sweep_latency", 32'(n), 32'd4);
    check("sweep_diff",    32'(diff3), 32'(r[2:0]));
    check("sweep_borrow",  32'(borrow3), 32'(r[3]));
    $display("t=%0t a=%0d b=%0d bin=%0d diff=%0d borrow=%0d", $time, ta, tb, tbin, diff3, borrow3);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] pa[3]   = '{8'd200, 8'd5,  8'h33};
  logic [7:0] pb[3]   = '{8'd55,  8'd10, 8'h11};
  logic       pbin[3] = '{1'b0,   1'b0,  1'b1};
  logic [7:0] ped[3]  = '{8'd145, 8'd251, 8'h21};
  logic       peb[3]  = '{1'b0,   1'b1,  1'b0};

  initial begin
    int nd;
    int dc[3];
    int seen;

    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    start3 = 0; a3 = 0; b3 = 0; bin3 = 0;

    // Reset values appear before any clock edge.
    #1;
    check("rst_busy8",   32'(busy8),   32'd0);
    check("rst_done8",   32'(done8),   32'd0);
    check("rst_diff8",   32'(diff8),   32'd0);
    check("rst_borrow8", 32'(borrow8), 32'd0);
    check("rst_state8",  32'(st8),     32'(IDLE));
    check("rst_diff3",   32'(diff3),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op8(8'd200, 8'd55, 1'b0, 8'd145, 1'b0, "op_200_55");
    op8(8'd5,   8'd10, 1'b0, 8'd251, 1'b1, "op_5_10");
    op8(8'd0,   8'd0,  1'b1, 8'hFF,  1'b1, "op_0_0_bin");
    op8(8'h80,  8'h80, 1'b0, 8'h00,  1'b0, "op_80_80");

    // Back-to-back: start held high, operands scrambled while running.
    nd = 0;
    @(negedge clk);
    a8 = pa[0]; b8 = pb[0]; bin8 = pbin[0]; start8 = 1'b1;
    for (int t = 0; t < 40 && nd < 3; t++) begin
      @(negedge clk);
      if (done8) begin
        dc[nd] = cyc;
        check("b2b_diff",   32'(diff8),   32'(ped[nd]));
        check("b2b_borrow", 32'(borrow8), 32'(peb[nd]));
        nd++;
        if (nd < 3) begin
          a8 = pa[nd]; b8 = pb[nd]; bin8 = pbin[nd];
        end
      end else begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom_range(0, 1));
      end
    end
    start8 = 1'b0;
    check("b2b_pulses", 32'(nd), 32'd3);
    if (nd == 3) begin
      check("b2b_gap1", 32'(dc[1] - dc[0]), 32'd9);
      check("b2b_gap2", 32'(dc[2] - dc[1]), 32'd9);
    end
    repeat (2) @(negedge clk);

    // Abort in the fourth RUN cycle; results were nonzero before.
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd13; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",   32'(busy8),   32'd0);
    check("abort_done",   32'(done8),   32'd0);
    check("abort_diff",   32'(diff8),   32'd0);
    check("abort_borrow", 32'(borrow8), 32'd0);
    check("abort_state",  32'(st8),     32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    op8(8'd77, 8'd13, 1'b0, 8'd64, 1'b0, "op_after_abort");

    // Exhaustive 3-bit sweep.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int c = 0; c < 2; c++)
          op3(3'(i), 3'(j), 1'(c));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (pass=%0d total=%0d)", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
